// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state type, byte framing constants and
// a small state classification helper. Intended to be shared with i2c_write.
`timescale 1ns/1ps

package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_slave_state_t;

    localparam int unsigned I2C_BITS_PER_BYTE = 8;
    localparam logic        I2C_RW_WRITE      = 1'b0;

    // States that shift in bits; a STOP in one of these with bits pending is a truncated frame
    function automatic logic is_byte_state(input i2c_slave_state_t s);
        return (s == ADDR) || (s == REG) || (s == DATA);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// One bus line into the sys_clk domain: 2-flop synchroniser (preset to the
// idle-high bus level), optional stability filter, and rise/fall detect.
// Build option: define I2C_FILTER_EN to insert the FILTER_LEN-sample filter.
// Edge outputs are combinational from the last stage, so a pin change is acted
// on by the consumer 3 sys_clk later (3+FILTER_LEN with the filter).
`timescale 1ns/1ps

module i2c_line_sync #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

`ifdef I2C_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    // Two-stage synchroniser, idles high like the bus
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (FILTER_ON && (FILTER_LEN > 1)) begin : g_filter
            localparam int unsigned     CNT_W    = $clog2(FILTER_LEN);
            localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FILTER_LEN - 1);

            logic             r_filt;
            logic [CNT_W-1:0] r_cnt;

            // Down-counter runs while the input disagrees with the held level;
            // the level flips only when FILTER_LEN consecutive samples disagree
            always_ff @(posedge sys_clk or negedge rst) begin
                if (!rst) begin
                    r_filt <= 1'b1;
                    r_cnt  <= CNT_LOAD;
                end else if (r_sync2 == r_filt) begin
                    r_cnt <= CNT_LOAD;
                end else if (r_cnt == '0) begin
                    r_filt <= r_sync2;
                    r_cnt  <= CNT_LOAD;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_level = r_filt;
        end else begin : g_bypass
            assign w_level = r_sync2;
        end
    endgenerate

    // Previous level for edge detection
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_reg_slave.sv
// Write-only I2C register target, oversampled in the sys_clk domain.
// Accepts START, addr+W, register byte, data bytes..., STOP and emits one
// reg_wr strobe per data byte with an auto-incrementing register pointer.
// Never drives SCL. Build option: I2C_FILTER_EN (line glitch filter).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus free or unaddressed, waiting for START
// ADDR     | shifting in 7-bit address + R/W
// ADDR_ACK | address matched, driving ACK for one SCL low/high period
// REG      | shifting in register pointer byte
// REG_ACK  | acknowledging register pointer
// DATA     | shifting in data byte
// DATA_ACK | acknowledging data byte (strobe already issued)
// IGNORE   | not for us (other address or read), wait for START/STOP
`timescale 1ns/1ps

module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h1A,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       reg_wr,
    output logic       busy,
    output logic       err
);

    localparam logic [2:0] LAST_BIT = 3'(I2C_BITS_PER_BYTE - 1);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic [7:0] w_byte;

    i2c_slave_state_t r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [6:0] r_shift, w_shift_nxt;
    logic       r_bit_pend, w_bit_pend_nxt;
    logic       r_ack_half, w_ack_half_nxt;
    logic       r_inc_pend, w_inc_pend_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_err, w_err_nxt;
    logic       r_reg_wr, w_reg_wr_nxt;
    logic [7:0] r_reg_addr, w_reg_addr_nxt;
    logic [7:0] r_reg_data, w_reg_data_nxt;

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
        .sys_clk (sys_clk),
        .rst     (rst),
        .i_line  (scl_in),
        .o_level (w_scl_lvl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
        .sys_clk (sys_clk),
        .rst     (rst),
        .i_line  (sda_in),
        .o_level (w_sda_lvl),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl_lvl;
    assign w_stop  = w_sda_rise & w_scl_lvl;
    assign w_byte  = {r_shift, w_sda_lvl};

    // Next-state and output decode; START/STOP pre-empt any SCL edge in the same cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_bit_pend_nxt = r_bit_pend;
        w_ack_half_nxt = r_ack_half;
        w_inc_pend_nxt = 1'b0;
        w_sda_oe_nxt   = r_sda_oe;
        w_busy_nxt     = r_busy;
        w_err_nxt      = r_err;
        w_reg_wr_nxt   = 1'b0;
        w_reg_addr_nxt = r_reg_addr;
        w_reg_data_nxt = r_reg_data;

        if (r_inc_pend) begin
            w_reg_addr_nxt = r_reg_addr + 8'd1;
        end

        if (w_scl_fall) begin
            w_bit_pend_nxt = 1'b0;
        end

        if (w_start) begin
            w_state_nxt    = ADDR;
            w_bit_cnt_nxt  = '0;
            w_bit_pend_nxt = 1'b0;
            w_ack_half_nxt = 1'b0;
            w_sda_oe_nxt   = 1'b0;
            w_err_nxt      = 1'b0;
        end else if (w_stop) begin
            // The SCL rise that sets up a STOP is sampled like a bit; it only
            // becomes a real bit once SCL falls again, so it is not counted here.
            if (is_byte_state(r_state) &&
                ((r_bit_cnt - {2'b00, r_bit_pend}) != 3'd0)) begin
                w_err_nxt = 1'b1;
            end
            w_state_nxt    = IDLE;
            w_bit_cnt_nxt  = '0;
            w_bit_pend_nxt = 1'b0;
            w_ack_half_nxt = 1'b0;
            w_sda_oe_nxt   = 1'b0;
            w_busy_nxt     = 1'b0;
        end else begin
            case (r_state)
                ADDR, REG, DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt    = w_byte[6:0];
                        w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                        w_bit_pend_nxt = 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            if (r_state == ADDR) begin
                                if ((w_byte[7:1] == SLAVE_ADDR) && (w_byte[0] == I2C_RW_WRITE)) begin
                                    w_state_nxt = ADDR_ACK;
                                    w_busy_nxt  = 1'b1;
                                end else begin
                                    w_state_nxt = IGNORE;
                                    w_busy_nxt  = 1'b0;
                                end
                            end else if (r_state == REG) begin
                                w_reg_addr_nxt = w_byte;
                                w_state_nxt    = REG_ACK;
                            end else begin
                                w_reg_data_nxt = w_byte;
                                w_reg_wr_nxt   = 1'b1;
                                w_inc_pend_nxt = 1'b1;
                                w_state_nxt    = DATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, REG_ACK, DATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_half) begin
                            w_sda_oe_nxt   = 1'b1;
                            w_ack_half_nxt = 1'b1;
                        end else begin
                            w_sda_oe_nxt   = 1'b0;
                            w_ack_half_nxt = 1'b0;
                            w_state_nxt    = (r_state == ADDR_ACK) ? REG : DATA;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_bit_pend <= 1'b0;
            r_ack_half <= 1'b0;
            r_inc_pend <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_pend <= w_bit_pend_nxt;
            r_ack_half <= w_ack_half_nxt;
            r_inc_pend <= w_inc_pend_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= w_err_nxt;
            r_reg_wr   <= w_reg_wr_nxt;
            r_reg_addr <= w_reg_addr_nxt;
            r_reg_data <= w_reg_data_nxt;
        end
    end

    assign sda_oe   = r_sda_oe;
    assign reg_addr = r_reg_addr;
    assign reg_data = r_reg_data;
    assign reg_wr   = r_reg_wr;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
I2C write-only responder that receives frames of the form START, address+W, register byte, one or more data bytes, STOP.
- Each received data byte is presented as a one-cycle register-write strobe.
- It is the counterpart of i2c_write: a loopback target on GPIO_0 for bench/board tests, and the receive front end for future on-chip control registers.
- Runs fully in the sys_clk domain by oversampling SCL/SDA; it never drives SCL (no clock stretching).

Parameters:
SLAVE_ADDR, 7'h1A, 7-bit bus address answered with ACK
FILTER_LEN, 4, sys_clk cycles a line must be stable before it is accepted (only used with I2C_FILTER_EN)

Ports:
sys_clk  in  1  system clock, must be >= 20x SCL frequency
rst  in  1  asynchronous active-low reset
scl_in  in  1  SCL pin level
sda_in  in  1  SDA pin level
sda_oe  out  1  1 = pull SDA low (open-drain ACK); 0 = release
reg_addr  out  8  register pointer for current write
reg_data  out  8  received data byte
reg_wr  out  1  one-cycle strobe; reg_addr/reg_data valid in same cycle
busy  out  1  1 from addressed START until STOP/abort
err  out  1  sticky: frame ended mid-byte; cleared by next START

Behaviour:
- Reset (rst=0, async): sda_oe=0, reg_wr=0, busy=0, err=0, reg_addr=0, reg_data=0, state=IDLE; sync flops preset to 1 (idle bus).
- Input path:
  - 2-flop synchroniser per line, then edge detect.
  - An event is visible 3 sys_clk after the pin change.
- Events:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Bits are sampled on the SCL rising edge, MSB first.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: START -> ADDR; everything else ignored.
  - ADDR, after 8th bit:
    - If addr==SLAVE_ADDR and R/W=0 -> ADDR_ACK, busy=1.
    - Otherwise (mismatch or read) -> IGNORE: no ACK, SDA released.
  - X_ACK:
    - On the first SCL falling edge after the 8th bit, sda_oe=1.
    - On the next SCL falling edge, sda_oe=0 and go to the next byte state: ADDR_ACK->REG, REG_ACK->DATA, DATA_ACK->DATA.
  - REG: after 8 bits, reg_addr <= byte.
  - DATA: after the 8th bit, reg_data <= byte and reg_wr=1 for exactly one cycle (cycle after the rising-edge event).
    - reg_addr is incremented by 1 (mod 256, 8'hFF wraps to 8'h00) one cycle after the strobe.
    - The next byte therefore targets reg_addr+1.
  - IGNORE: waits for START or STOP.
- START in any state (repeated start):
  - Bit counter cleared, go to ADDR, sda_oe=0, err=0.
  - reg_addr is kept.
- STOP in any state:
  - -> IDLE, busy=0, sda_oe=0.
  - If the bit counter is not 0 and the state is a byte state (ADDR/REG/DATA), err=1.
  - No strobe for a partial byte.
- START/STOP precedence: a START or STOP detected in the same cycle as an SCL edge wins; the SCL edge is discarded.
- The bit counter is 3 bits and wraps 7->0 with the byte-complete action.
- Rst deassertion mid-frame: the block is in IDLE and ignores traffic until the next START.

Optional Feature:
Macro I2C_FILTER_EN.
- Defined: each synchronised line passes a stability filter. The output updates only after FILTER_LEN consecutive equal samples; glitches shorter than FILTER_LEN cycles are suppressed. Latency becomes 3+FILTER_LEN sys_clk.
- Undefined: no filter; 3-cycle latency; a 1-cycle glitch on SCL counts as an edge.

Decomposition:
- Package i2c_pkg:
  - State enum type i2c_slave_state_t.
  - Constants I2C_BITS_PER_BYTE=8, I2C_RW_WRITE=1'b0.
  - Shared with i2c_write when it is refactored.
- Sub-module i2c_line_sync:
  - Synchroniser, optional filter, and rise/fall detect for one line.
  - Instantiated twice (SCL, SDA).
  - Outputs level, rise, fall.

Test Plan:
- Bus model at 100 kHz, sys_clk 50 MHz. Frame 0x34(0x1A+W), 0x04, 0x5A, STOP -> three ACKs (SDA low on 9th clock each byte); single reg_wr with reg_addr=0x04, reg_data=0x5A; busy low after STOP.
- Frame 0x36 (addr 0x1B), 0x04, 0x5A -> no ACK on any clock; reg_wr never asserts; busy stays 0.
- Burst 0x34, 0xFE, 0x11, 0x22, 0x33, STOP -> strobes (0xFE,0x11), (0xFF,0x22), (0x00,0x33) showing wrap.
- Read request 0x35 -> NACK, state IGNORE; then repeated START + 0x34, 0x10, 0xAA -> strobe (0x10,0xAA), err=0.
- STOP after 4 bits of data byte -> no strobe, err=1; next START clears err. Separately, rst=0 mid-byte -> all outputs 0 immediately, no strobe after release.
- With I2C_FILTER_EN and FILTER_LEN=4: 2-cycle SCL low glitch inside a high phase -> no bit sampled and data received intact. Without the macro, the same stimulus shifts in an extra bit.
